// File: rtl/UART_MIKE_pkg.sv
// Shared definitions for the UART receive-side FIFO: default widths/depths
// and the acknowledge FSM state encoding.
package UART_MIKE_pkg;

    localparam int UART_DATA_WIDTH    = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } rx_fifo_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// Occupancy is tracked in an explicit level counter so full/empty never
// depend on pointer equality alone. Pushes into a full FIFO and pops from
// an empty FIFO are ignored.
module uart_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   level_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    assign full      = (level_r == (ADDR_WIDTH+1)'(DEPTH));
    assign empty     = (level_r == '0);
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign rd_data   = mem_r[rd_ptr_r];
    assign level     = level_r;

    // Storage write; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); level tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + (ADDR_WIDTH+1)'(1);
                2'b01:   level_r <= level_r - (ADDR_WIDTH+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer between the UART receiver and its consumer.
// Captures each byte flagged by rx_flag into a FIFO and acknowledges it
// with an active-low, registered rx_flag_clr pulse held until rx_flag drops.
// Optional feature macro: UART_RX_FIFO_OVF_EN -- when defined, a byte that
// arrives while the FIFO is full is dropped and acknowledged and the sticky
// ovf_error flag is raised; otherwise a full FIFO backpressures the receiver
// by withholding the acknowledge.
module uart_rx_fifo
    import UART_MIKE_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = UART_RX_FIFO_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_flag,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_flag_clr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  ovf_error,
    input  logic                  ovf_clr
);

    rx_fifo_state_t state_r;
    rx_fifo_state_t state_nx_s;
    logic           rx_flag_clr_r;
    logic           push_s;
    logic           pop_s;
    logic           overflow_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .wr_data (rx_data),
        .pop     (pop_s),
        .rd_data (rd_data),
        .level   (level),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign pop_s       = ~fifo_empty_s & rd_ready;
    assign rd_valid    = ~fifo_empty_s;
    assign full        = fifo_full_s;
    assign rx_flag_clr = rx_flag_clr_r;

    // Acknowledge FSM next state: capture in IDLE, wait for rx_flag to drop in ACK.
    always_comb begin
        state_nx_s = state_r;
        push_s     = 1'b0;
        overflow_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (rx_flag) begin
                    if (!fifo_full_s) begin
                        push_s     = 1'b1;
                        state_nx_s = ACK;
                    end else begin
`ifdef UART_RX_FIFO_OVF_EN
                        overflow_s = 1'b1;
                        state_nx_s = ACK;
`else
                        state_nx_s = IDLE;
`endif
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ACK: begin
                if (!rx_flag) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = ACK;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register; the acknowledge output mirrors the next state so it
    // goes low on the same edge the byte is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            rx_flag_clr_r <= 1'b1;
        end else begin
            state_r       <= state_nx_s;
            rx_flag_clr_r <= (state_nx_s != ACK);
        end
    end

`ifdef UART_RX_FIFO_OVF_EN
    logic ovf_error_r;

    // Sticky overflow flag; a new overflow wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_error_r <= 1'b0;
        end else if (overflow_s) begin
            ovf_error_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_error_r <= 1'b0;
        end else begin
            ovf_error_r <= ovf_error_r;
        end
    end

    assign ovf_error = ovf_error_r;
`else
    logic unused_ovf_s;
    assign unused_ovf_s = ^{ovf_clr, overflow_s};
    assign ovf_error    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a per-cycle vector table for the
// basic handshake/read behaviour, then hand-written sequences for burst
// fill/drain with wrap, full-FIFO handling, simultaneous push/pop and reset.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_flag;
    logic [DW-1:0] rx_data;
    logic          rx_flag_clr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW:0]   level;
    logic          full;
    logic          ovf_error;
    logic          ovf_clr;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       flag;
        logic [7:0] data;
        logic       ready;
        logic       e_valid;
        logic [7:0] e_data;
        logic [4:0] e_level;
        logic       e_full;
        logic       e_clr;
    } vec_t;

    vec_t vecs[14];

    uart_rx_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .rx_flag     (rx_flag),
        .rx_data     (rx_data),
        .rx_flag_clr (rx_flag_clr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .level       (level),
        .full        (full),
        .ovf_error   (ovf_error),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Receiver model: hold byte until the clear is seen, hold one more cycle, then drop.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_flag = 1'b1;
        rx_data = b;
        while (rx_flag_clr !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check("ack_seen", rx_flag_clr, 32'd0);
        if (rx_flag_clr === 1'b0) begin
            tick();
            check("ack_hold", rx_flag_clr, 32'd0);
        end
        rx_flag = 1'b0;
        tick();
        check("ack_release", rx_flag_clr, 32'd1);
        exp_q.push_back(b);
    endtask

    // Check the head against the model and pop it.
    task automatic pop_check(input string name);
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
        check({name, "_valid"}, rd_valid, 32'd1);
        check({name, "_data"}, rd_data, e);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        //               flag  data   rdy   valid e_data e_lvl full  clr
        vecs[0]  = '{1'b1, 8'h41, 1'b0, 1'b1, 8'h41, 5'd1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h41, 1'b0, 1'b1, 8'h41, 5'd1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 5'd1, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 8'h7E, 1'b0, 1'b1, 8'h3C, 5'd2, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'h7E, 1'b1, 1'b1, 8'h7E, 5'd1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h7E, 5'd1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1};

        rst      = 1'b1;
        rx_flag  = 1'b0;
        rx_data  = 8'h00;
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;
        tick();
        tick();
        check("rst_clr", rx_flag_clr, 32'd1);
        check("rst_valid", rd_valid, 32'd0);
        check("rst_level", level, 32'd0);
        check("rst_full", full, 32'd0);
        check("rst_ovf", ovf_error, 32'd0);
        rst = 1'b0;
        tick();

        // Per-cycle vectors: single byte handshake, pops during ACK, empty reads.
        for (int i = 0; i < 14; i++) begin
            logic [15:0] act;
            logic [15:0] exp;
            rx_flag  = vecs[i].flag;
            rx_data  = vecs[i].data;
            rd_ready = vecs[i].ready;
            tick();
            act = {rd_valid, (vecs[i].e_valid ? rd_data : 8'h00), level, full, rx_flag_clr};
            exp = {vecs[i].e_valid, (vecs[i].e_valid ? vecs[i].e_data : 8'h00),
                   vecs[i].e_level, vecs[i].e_full, vecs[i].e_clr};
            check($sformatf("vec%0d", i), act, exp);
        end
        rx_flag  = 1'b0;
        rd_ready = 1'b0;
        tick();

        // Burst fill to full, drain in order, then refill (pointers wrap).
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i));
        end
        check("fill1_full", full, 32'd1);
        check("fill1_level", level, 32'd16);
        for (int i = 0; i < 16; i++) begin
            pop_check("drain1");
        end
        check("drain1_level", level, 32'd0);
        check("drain1_valid", rd_valid, 32'd0);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(8'h10 + i));
        end
        check("fill2_full", full, 32'd1);
        check("fill2_level", level, 32'd16);

`ifdef UART_RX_FIFO_OVF_EN
        // Overflow: byte dropped and acknowledged, sticky flag, set beats clear.
        rx_flag = 1'b1;
        rx_data = 8'h55;
        tick();
        check("ovf_ack", rx_flag_clr, 32'd0);
        check("ovf_set", ovf_error, 32'd1);
        check("ovf_level", level, 32'd16);
        tick();
        rx_flag = 1'b0;
        tick();
        check("ovf_release", rx_flag_clr, 32'd1);
        check("ovf_sticky", ovf_error, 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", ovf_error, 32'd0);
        ovf_clr = 1'b1;
        rx_flag = 1'b1;
        rx_data = 8'h66;
        tick();
        ovf_clr = 1'b0;
        check("ovf_set_prio", ovf_error, 32'd1);
        check("ovf2_level", level, 32'd16);
        tick();
        rx_flag = 1'b0;
        tick();
`else
        // Backpressure: no acknowledge while full; one pop lets the byte in.
        rx_flag = 1'b1;
        rx_data = 8'h55;
        repeat (4) tick();
        check("bp_no_ack", rx_flag_clr, 32'd1);
        check("bp_level", level, 32'd16);
        check("bp_ovf", ovf_error, 32'd0);
        check("bp_head", rd_data, 32'h10);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        void'(exp_q.pop_front());
        check("bp_pop_level", level, 32'd15);
        check("bp_pop_clr", rx_flag_clr, 32'd1);
        tick();
        check("bp_push_level", level, 32'd16);
        check("bp_push_ack", rx_flag_clr, 32'd0);
        exp_q.push_back(8'h55);
        tick();
        rx_flag = 1'b0;
        tick();
        check("bp_release", rx_flag_clr, 32'd1);
`endif
        while (exp_q.size() > 0) begin
            pop_check("drain2");
        end
        check("drain2_level", level, 32'd0);

        // Simultaneous push and pop at level 3.
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        check("pp_level3", level, 32'd3);
        rx_flag  = 1'b1;
        rx_data  = 8'hA4;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("pp_level", level, 32'd3);
        check("pp_head", rd_data, 32'hA2);
        check("pp_ack", rx_flag_clr, 32'd0);
        void'(exp_q.pop_front());
        exp_q.push_back(8'hA4);
        tick();
        rx_flag = 1'b0;
        tick();
        check("pp_release", rx_flag_clr, 32'd1);
        while (exp_q.size() > 0) begin
            pop_check("pp_drain");
        end

        // Reset while in ACK with five bytes stored.
        for (int i = 0; i < 4; i++) begin
            send_byte(8'(8'hB0 + i));
        end
        rx_flag = 1'b1;
        rx_data = 8'hB4;
        tick();
        check("ra_level5", level, 32'd5);
        check("ra_ack", rx_flag_clr, 32'd0);
        rst     = 1'b1;
        rx_flag = 1'b0;
        tick();
        rst = 1'b0;
        check("ra_level", level, 32'd0);
        check("ra_valid", rd_valid, 32'd0);
        check("ra_clr", rx_flag_clr, 32'd1);
        check("ra_full", full, 32'd0);
        tick();
        check("ra_idle_clr", rx_flag_clr, 32'd1);
        exp_q.delete();
        rx_flag = 1'b1;
        rx_data = 8'hC7;
        tick();
        check("ra_recapture_level", level, 32'd1);
        check("ra_recapture_ack", rx_flag_clr, 32'd0);
        exp_q.push_back(8'hC7);
        tick();
        rx_flag = 1'b0;
        tick();
        pop_check("ra_pop");
        check("ra_final_level", level, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It collects each received byte presented on the receiver's rx_flag/rx_data pair into a synchronous FIFO. It then acknowledges the byte by pulsing the receiver's active-low rx_flag_clr input. Consumers read bytes through a first-word-fall-through valid/ready port, so software or a parser no longer has to service rx_flag byte by byte.

## Interface
- DATA_WIDTH, default UART_DATA_WIDTH (8): byte width; must match the receiver.
- DEPTH, default UART_RX_FIFO_DEPTH (16): entries; power of two, at least 2.
- ADDR_WIDTH, default $clog2(DEPTH): pointer width (derived; do not override).

Ports:
- clk  in  1: single clock; shared with the UART receiver.
- rst  in  1: synchronous, active-high reset.
- rx_flag  in  1: receiver "byte available" level; held until acknowledged.
- rx_data  in  DATA_WIDTH: receiver byte; stable while rx_flag=1.
- rx_flag_clr  out  1: active-low acknowledge to the receiver; registered; idle 1.
- rd_data  out  DATA_WIDTH: head-of-FIFO byte; valid while rd_valid=1.
- rd_valid  out  1: FIFO not empty.
- rd_ready  in  1: consumer accepts rd_data this cycle.
- level  out  ADDR_WIDTH+1: current occupancy, 0..DEPTH.
- full  out  1: level==DEPTH.
- ovf_error  out  1: sticky overflow flag; constant 0 unless UART_RX_FIFO_OVF_EN is defined.
- ovf_clr  in  1: clears ovf_error; ignored unless UART_RX_FIFO_OVF_EN is defined.

## Operation
- Reset values: state IDLE, pointers and level 0, rx_flag_clr=1, rd_valid=0, full=0, ovf_error=0. rd_data is don't-care while rd_valid=0.
- FSM has two states: IDLE and ACK.
- IDLE, rx_flag=1, full=0: write rx_data at the write pointer, level+1, go to ACK.
- IDLE, rx_flag=1, full=1:
  - Without the macro: stay in IDLE (backpressure). The receiver is blocked because it will not start a new frame while rx_flag=1.
  - With the macro: drop the byte, set ovf_error, go to ACK.
- ACK: drive rx_flag_clr=0. Stay in ACK until rx_flag is sampled 0, then drive rx_flag_clr=1 and go to IDLE.
- Read port: a pop occurs when rd_valid & rd_ready. The pop advances the read pointer and decrements level. rd_ready while empty is ignored.
- Push and pop in the same cycle: level is unchanged and both pointers advance.
- Pop while full: the pop is performed. The pending push waits for IDLE on the next cycle, when full=0.
- Pointers wrap modulo DEPTH. full and empty are derived from level, never from pointer equality alone.
- ovf_error: setting has priority over ovf_clr in the same cycle.
- Reset mid-operation:
  - All state is cleared and stored bytes are discarded.
  - If rx_flag is still 1 after reset, that byte is captured again as a new byte.

## Timing
- rx_flag first sampled 1 at edge k:
  - The byte is written and state becomes ACK at edge k.
  - rd_valid=1 and rx_flag_clr=0 after edge k.
- The receiver registers the clear and drops rx_flag about 2 edges later. The block returns to IDLE and rx_flag_clr=1 one edge after rx_flag is seen low.
- A byte cannot be written twice, because IDLE is re-entered only after rx_flag=0.
- Read latency is 0 (fall-through): the written byte appears on rd_data in the cycle after edge k.
- level, full and rd_valid update on the same edge as the push or pop.

## Configuration
- UART_RX_FIFO_OVF_EN defined:
  - Overflow drops the incoming byte and acknowledges it.
  - ovf_error is sticky until ovf_clr.
- Not defined:
  - Full FIFO backpressures the receiver by withholding the acknowledge; no data is lost at the FIFO.
  - ovf_error is tied to 0 and ovf_clr is unused.

## Structure
- In UART_MIKE_pkg:
  - the rx_fifo_state_t enum (IDLE, ACK);
  - the UART_RX_FIFO_DEPTH constant.
- Sub-module uart_sync_fifo: storage array, pointers and level, with push/pop/full/empty. The top level contains the acknowledge FSM, the overflow logic and the read port mapping.

## Test plan
- Single byte: rx_flag=1 with rx_data=0x41 held until clear seen -> rx_flag_clr low for ≥2 cycles; rd_valid=1, rd_data=0x41, level=1; rd_ready pop -> level=0, rd_valid=0.
- Burst of 16 bytes 0x00..0x0F, no reads -> full=1, level=16; draining returns 0x00..0x0F in order, with pointer wrap verified on a second fill.
- Full, without the macro: 17th byte 0x55 -> rx_flag_clr stays 1. One pop -> 0x55 captured and acknowledged, level=16.
- Full, with the macro: 17th byte 0x55 -> acknowledged and dropped, ovf_error=1. ovf_clr and a new overflow in the same cycle -> ovf_error stays 1.
- Simultaneous push and pop at level 3 -> level stays 3, data order preserved.
- rst asserted while in ACK with level 5 -> next edge: level=0, rd_valid=0, rx_flag_clr=1, state IDLE.
